decode_stage: RTL and testbench

Registered RV32I/RV64I-capable instruction decode stage sitting between instruction fetch and register read / execute. It accepts one fetched instruction per cycle over a valid/ready handshake, fully decodes all base-ISA formats (R/I/S/B/U/J) including immediate generation and control signals, and presents the result from a 2-entry elastic buffer so fetch and execute are decoupled. It also flags illegal encodings and supports a pipeline flush.

---
 rtl/decode_stage.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I instruction decoder with a 2-entry elastic output buffer.
// Decode is purely combinational from the incoming word; the result is captured on
// accept into a main/skid register pair so fetch and execute stay decoupled.
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic            out_alusrc,
    output logic            out_load_from_pc,
    output logic            out_reg_write,
    output logic [1:0]      out_wb_src,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [2:0]      out_funct3,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_jalr,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic IS_RV64      = (XLEN == 64);
    localparam logic KEEP_ILLEGAL = (ILLEGAL_TRAP != 0);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alusrc;
        logic            load_from_pc;
        logic            reg_write;
        logic [1:0]      wb_src;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [5:0]      upper6;
    logic [5:0]      shamt;
    logic            shamt_ok;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic            legal;
    entry_t          dec;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign upper6 = in_instr[31:26];

    // Size casts of signed values sign-extend each immediate to the datapath width.
    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign imm_sh = XLEN'(shamt);

    // Shift amount is 6 bits wide on RV64; on RV32 a set shamt[5] makes the shift illegal.
    generate
        if (XLEN == 64) begin : g_rv64
            assign shamt    = in_instr[25:20];
            assign shamt_ok = 1'b1;
        end else begin : g_rv32
            assign shamt    = {1'b0, in_instr[24:20]};
            assign shamt_ok = ~in_instr[25];
        end
    endgenerate

    // Combinational decode of the incoming word into a buffer entry.
    always_comb begin
        dec    = '0;
        legal  = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.rd = in_instr[11:7]; dec.imm = imm_u; dec.alu_op = ALU_PASSB;
                dec.alusrc = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.rd = in_instr[11:7]; dec.imm = imm_u; dec.alu_op = ALU_ADD;
                dec.alusrc = 1'b1; dec.load_from_pc = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.rd = in_instr[11:7]; dec.imm = imm_j; dec.alu_op = ALU_ADD;
                dec.alusrc = 1'b1; dec.load_from_pc = 1'b1; dec.reg_write = 1'b1;
                dec.wb_src = 2'b10; dec.jump = 1'b1;
            end
            OPC_JALR: begin
                dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.imm = imm_i;
                dec.alu_op = ALU_ADD; dec.alusrc = 1'b1; dec.reg_write = 1'b1;
                dec.wb_src = 2'b10; dec.jalr = 1'b1;
                legal = (f3 == 3'd0);
            end
            OPC_BRANCH: begin
                dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.imm = imm_b;
                dec.alu_op = ALU_SUB; dec.load_from_pc = 1'b1; dec.branch = 1'b1;
                dec.funct3 = f3;
                legal = (f3 != 3'd2) && (f3 != 3'd3);
            end
            OPC_LOAD: begin
                dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.imm = imm_i;
                dec.alu_op = ALU_ADD; dec.alusrc = 1'b1; dec.reg_write = 1'b1;
                dec.wb_src = 2'b01; dec.mem_read = 1'b1; dec.funct3 = f3;
                legal = (f3 == 3'd3 || f3 == 3'd6) ? IS_RV64 : (f3 != 3'd7);
            end
            OPC_STORE: begin
                dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.imm = imm_s;
                dec.alu_op = ALU_ADD; dec.alusrc = 1'b1; dec.mem_write = 1'b1;
                dec.funct3 = f3;
                legal = (f3 < 3'd3) || (f3 == 3'd3 && IS_RV64);
            end
            OPC_OPIMM: begin
                dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.imm = imm_i;
                dec.alusrc = 1'b1; dec.reg_write = 1'b1;
                case (f3)
                    3'd0: dec.alu_op = ALU_ADD;
                    3'd1: begin
                        dec.alu_op = ALU_SLL; dec.imm = imm_sh;
                        legal = (upper6 == 6'd0) && shamt_ok;
                    end
                    3'd2: dec.alu_op = ALU_SLT;
                    3'd3: dec.alu_op = ALU_SLTU;
                    3'd4: dec.alu_op = ALU_XOR;
                    3'd5: begin
                        dec.alu_op = in_instr[30] ? ALU_SRA : ALU_SRL; dec.imm = imm_sh;
                        legal = (upper6 == 6'd0 || upper6 == 6'b010000) && shamt_ok;
                    end
                    3'd6: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
                dec.reg_write = 1'b1;
                case (f3)
                    3'd0: dec.alu_op = in_instr[30] ? ALU_SUB : ALU_ADD;
                    3'd1: dec.alu_op = ALU_SLL;
                    3'd2: dec.alu_op = ALU_SLT;
                    3'd3: dec.alu_op = ALU_SLTU;
                    3'd4: dec.alu_op = ALU_XOR;
                    3'd5: dec.alu_op = in_instr[30] ? ALU_SRA : ALU_SRL;
                    3'd6: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
                legal = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
            end
            default: legal = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
        // Illegal entries carry only their PC and the flag, so no side effect can leak.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.pc = in_pc;
    end

    logic [1:0] state_reg, state_next;
    entry_t     main_reg, main_next;
    entry_t     skid_reg, skid_next;
    logic       push, pop;

    assign in_ready  = (state_reg != ST_TWO);
    assign out_valid = (state_reg != ST_EMPTY);
    assign push      = in_valid & in_ready & (~dec.illegal | KEEP_ILLEGAL);
    assign pop       = out_valid & out_ready;

    // Elastic buffer next state: main always holds the oldest entry, skid the younger.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (push) begin
                    main_next  = dec;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_next = dec;
                end else if (push) begin
                    skid_next  = dec;
                    state_next = ST_TWO;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    main_next  = skid_reg;
                    state_next = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush) begin
            state_next = ST_EMPTY;
            main_next  = main_reg;
            skid_next  = skid_reg;
        end
    end

    // Buffer registers; reset clears the payload so outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    assign out_pc           = main_reg.pc;
    assign out_rs1          = main_reg.rs1;
    assign out_rs2          = main_reg.rs2;
    assign out_rd           = main_reg.rd;
    assign out_imm          = main_reg.imm;
    assign out_alu_op       = main_reg.alu_op;
    assign out_alusrc       = main_reg.alusrc;
    assign out_load_from_pc = main_reg.load_from_pc;
    assign out_reg_write    = main_reg.reg_write;
    assign out_wb_src       = main_reg.wb_src;
    assign out_mem_read     = main_reg.mem_read;
    assign out_mem_write    = main_reg.mem_write;
    assign out_funct3       = main_reg.funct3;
    assign out_branch       = main_reg.branch;
    assign out_jump         = main_reg.jump;
    assign out_jalr         = main_reg.jalr;
    assign out_illegal      = main_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives three decode_stage instances (RV32 trapping, RV64 trapping,
// RV32 dropping illegals) from one stimulus stream and compares them every cycle
// against a queue-level reference model, plus directed decode checks.
module tb_decode_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [3:0]  alu_op;
        logic        alusrc;
        logic        lfp;
        logic        rw;
        logic [1:0]  wb;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic        br;
        logic        j;
        logic        jr;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    ent_t obs_ent   [3];
    logic obs_valid [3];
    logic obs_ready [3];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each instance is a FIFO of at most two decoded entries.
    ent_t mq   [3][2];
    int   mcnt [3];
    bit   mzero[3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int XL = (gi == 1) ? 64 : 32;
        localparam int TR = (gi == 2) ? 0 : 1;
        logic [XL-1:0] pc_o, imm_o;
        logic [4:0]    rs1_o, rs2_o, rd_o;
        logic [3:0]    alu_o;
        logic [1:0]    wb_o;
        logic [2:0]    f3_o;
        logic          valid_o, ready_o, alusrc_o, lfp_o, rw_o, mr_o, mw_o, br_o, j_o, jr_o, ill_o;

        decode_stage #(.XLEN(XL), .ILLEGAL_TRAP(TR)) u_dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(ready_o),
            .in_instr(in_instr), .in_pc(in_pc[XL-1:0]),
            .out_valid(valid_o), .out_ready(out_ready),
            .out_pc(pc_o), .out_rs1(rs1_o), .out_rs2(rs2_o), .out_rd(rd_o),
            .out_imm(imm_o), .out_alu_op(alu_o), .out_alusrc(alusrc_o),
            .out_load_from_pc(lfp_o), .out_reg_write(rw_o), .out_wb_src(wb_o),
            .out_mem_read(mr_o), .out_mem_write(mw_o), .out_funct3(f3_o),
            .out_branch(br_o), .out_jump(j_o), .out_jalr(jr_o), .out_illegal(ill_o)
        );

        assign obs_ent[gi]   = {64'(pc_o), rs1_o, rs2_o, rd_o, 64'(imm_o), alu_o, alusrc_o, lfp_o,
                                rw_o, wb_o, mr_o, mw_o, f3_o, br_o, j_o, jr_o, ill_o};
        assign obs_valid[gi] = valid_o;
        assign obs_ready[gi] = ready_o;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decode by the ISA rules, with immediates assembled arithmetically from the word.
    function automatic ent_t ref_decode(input logic [31:0] w, input logic [63:0] pc, input bit rv64);
        ent_t        e;
        int          si, tmp, up6;
        longint      imm;
        logic [2:0]  f3;
        bit          ok;
        logic [7:0]  ld_ok;
        logic [3:0]  alu_tab [8];
        alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        si  = int'(w);
        up6 = int'(w[31:26]);
        f3  = w[14:12];
        e   = '0;
        ok  = 1'b1;
        tmp = 0;
        case (w[6:0])
            7'h37: begin e.rd = w[11:7]; tmp = si & -4096; e.alu_op = 4'd10; e.alusrc = 1; e.rw = 1; end
            7'h17: begin e.rd = w[11:7]; tmp = si & -4096; e.alusrc = 1; e.lfp = 1; e.rw = 1; end
            7'h6F: begin
                e.rd = w[11:7];
                tmp = (si >>> 31) * 1048576 + ((si >>> 12) & 255) * 4096
                    + ((si >>> 20) & 1) * 2048 + ((si >>> 21) & 1023) * 2;
                e.alusrc = 1; e.lfp = 1; e.rw = 1; e.wb = 2'b10; e.j = 1;
            end
            7'h67: begin
                e.rd = w[11:7]; e.rs1 = w[19:15]; tmp = si >>> 20;
                e.alusrc = 1; e.rw = 1; e.wb = 2'b10; e.jr = 1; ok = (f3 == 3'd0);
            end
            7'h63: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3;
                tmp = (si >>> 31) * 4096 + ((si >>> 7) & 1) * 2048
                    + ((si >>> 25) & 63) * 32 + ((si >>> 8) & 15) * 2;
                e.alu_op = 4'd1; e.lfp = 1; e.br = 1; ok = (f3 != 3'd2 && f3 != 3'd3);
            end
            7'h03: begin
                e.rs1 = w[19:15]; e.rd = w[11:7]; e.f3 = f3; tmp = si >>> 20;
                e.alusrc = 1; e.rw = 1; e.wb = 2'b01; e.mr = 1;
                ld_ok = rv64 ? 8'h7F : 8'h37; ok = ld_ok[f3];
            end
            7'h23: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3;
                tmp = (si >>> 25) * 32 + ((si >>> 7) & 31);
                e.alusrc = 1; e.mw = 1; ok = (int'(f3) < (rv64 ? 4 : 3));
            end
            7'h13: begin
                e.rs1 = w[19:15]; e.rd = w[11:7]; e.alusrc = 1; e.rw = 1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    tmp = (si >>> 20) & (rv64 ? 63 : 31);
                    e.alu_op = (f3 == 3'd1) ? 4'd2 : (w[30] ? 4'd7 : 4'd6);
                    ok = ((f3 == 3'd1) ? (up6 == 0) : (up6 == 0 || up6 == 16)) && (rv64 || !w[25]);
                end else begin
                    tmp = si >>> 20;
                    e.alu_op = alu_tab[f3];
                end
            end
            7'h33: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.rw = 1;
                e.alu_op = alu_tab[f3] + 4'(w[31:25] == 7'h20);
                ok = (w[31:25] == 7'h00) || (w[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            default: ok = 1'b0;
        endcase
        imm   = tmp;
        e.imm = rv64 ? imm : (imm & 64'hFFFF_FFFF);
        if (e.rd == 5'd0) e.rw = 1'b0;
        if (!ok) begin
            e     = '0;
            e.ill = 1'b1;
        end
        e.pc = rv64 ? pc : (pc & 64'hFFFF_FFFF);
        return e;
    endfunction

    // Apply one clock edge to the model using the inputs that were present at that edge.
    task automatic model_update();
        ent_t e;
        bit   can_acc;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mcnt[k]  = 0;
                mzero[k] = 1'b1;
            end else if (flush) begin
                mcnt[k] = 0;
            end else begin
                can_acc = in_valid && (mcnt[k] < 2);
                if (out_ready && mcnt[k] > 0) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (can_acc) begin
                    e = ref_decode(in_instr, in_pc, k == 1);
                    if (!e.ill || k != 2) begin
                        mq[k][mcnt[k]] = e;
                        mcnt[k]++;
                        mzero[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic cmp_ent(input int k, input ent_t o, input ent_t x);
        string p;
        p = $sformatf("d%0d.", k);
        check({p, "pc"}, o.pc, x.pc);        check({p, "rs1"}, o.rs1, x.rs1);
        check({p, "rs2"}, o.rs2, x.rs2);     check({p, "rd"}, o.rd, x.rd);
        check({p, "imm"}, o.imm, x.imm);     check({p, "alu_op"}, o.alu_op, x.alu_op);
        check({p, "alusrc"}, o.alusrc, x.alusrc);
        check({p, "load_from_pc"}, o.lfp, x.lfp);
        check({p, "reg_write"}, o.rw, x.rw); check({p, "wb_src"}, o.wb, x.wb);
        check({p, "mem_read"}, o.mr, x.mr);  check({p, "mem_write"}, o.mw, x.mw);
        check({p, "funct3"}, o.f3, x.f3);    check({p, "branch"}, o.br, x.br);
        check({p, "jump"}, o.j, x.j);        check({p, "jalr"}, o.jr, x.jr);
        check({p, "illegal"}, o.ill, x.ill);
    endtask

    task automatic monitor();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d.out_valid", k), 64'(obs_valid[k]), 64'(mcnt[k] > 0));
            check($sformatf("d%0d.in_ready", k), 64'(obs_ready[k]), 64'(mcnt[k] < 2));
            if (mcnt[k] > 0)   cmp_ent(k, obs_ent[k], mq[k][0]);
            else if (mzero[k]) cmp_ent(k, obs_ent[k], '0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        monitor();
    endtask

    task automatic send1(input logic [31:0] w, input logic [63:0] pc);
        in_valid = 1'b1; in_instr = w; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 1) w[14:12] = 3'd0; end
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 1) w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00;
            end
            8: begin
                w[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 64'h0;
        for (int k = 0; k < 3; k++) begin mcnt[k] = 0; mzero[k] = 1'b1; end
        tick();
        tick();
        check("reset.out_valid", 64'(obs_valid[0]), 64'd0);
        check("reset.in_ready", 64'(obs_ready[0]), 64'd1);
        check("reset.imm", obs_ent[0].imm, 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // addi x1, x0, 5
        send1(32'h0050_0093, 64'h100);
        check("addi.valid", 64'(obs_valid[0]), 64'd1);
        check("addi.rd", 64'(obs_ent[0].rd), 64'd1);
        check("addi.imm", obs_ent[0].imm, 64'd5);
        check("addi.alusrc", 64'(obs_ent[0].alusrc), 64'd1);
        check("addi.reg_write", 64'(obs_ent[0].rw), 64'd1);
        tick();

        // Three back-to-back with execute stalled: only two fit.
        out_ready = 1'b0;
        send1(32'h0010_0113, 64'h200);
        send1(32'h0020_0193, 64'h204);
        check("stall.in_ready", 64'(obs_ready[0]), 64'd0);
        check("stall.pc_a", obs_ent[0].pc, 64'h200);
        send1(32'h0030_0213, 64'h208);
        check("stall.hold_pc", obs_ent[0].pc, 64'h200);
        out_ready = 1'b1;
        tick();
        check("stall.ready_after_pop", 64'(obs_ready[0]), 64'd1);
        check("stall.pc_b", obs_ent[0].pc, 64'h204);
        tick();
        check("stall.drained", 64'(obs_valid[0]), 64'd0);

        send1(32'h1234_50B7, 64'h300);
        check("lui.imm", obs_ent[0].imm, 64'h1234_5000);
        check("lui.alu_op", 64'(obs_ent[0].alu_op), 64'd10);
        send1(32'hFE00_0EE3, 64'h304);
        check("beq.branch", 64'(obs_ent[0].br), 64'd1);
        check("beq.imm", obs_ent[0].imm, 64'hFFFF_FFFC);
        send1(32'h0080_00EF, 64'h308);
        check("jal.jump", 64'(obs_ent[0].j), 64'd1);
        check("jal.wb_src", 64'(obs_ent[0].wb), 64'd2);
        check("jal.imm", obs_ent[0].imm, 64'd8);
        send1(32'h0020_A223, 64'h30C);
        check("sw.mem_write", 64'(obs_ent[0].mw), 64'd1);
        check("sw.reg_write", 64'(obs_ent[0].rw), 64'd0);
        send1(32'h4000_0033, 64'h310);
        check("sub_x0.illegal", 64'(obs_ent[0].ill), 64'd0);
        check("sub_x0.reg_write", 64'(obs_ent[0].rw), 64'd0);
        check("sub_x0.alu_op", 64'(obs_ent[0].alu_op), 64'd1);
        send1(32'h0200_0033, 64'h314);
        check("mul.illegal", 64'(obs_ent[0].ill), 64'd1);
        check("mul.reg_write", 64'(obs_ent[0].rw), 64'd0);
        check("mul.dropped_valid", 64'(obs_valid[2]), 64'd0);
        send1(32'hFFF0_0093, 64'h318);
        check("rv64.imm_m1", obs_ent[1].imm, 64'hFFFF_FFFF_FFFF_FFFF);
        send1(32'h0210_9093, 64'h31C);
        check("rv64.slli33_legal", 64'(obs_ent[1].ill), 64'd0);
        check("rv64.slli33_imm", obs_ent[1].imm, 64'd33);
        check("rv32.slli33_illegal", 64'(obs_ent[0].ill), 64'd1);
        tick();

        // Flush from TWO with a concurrent instruction.
        out_ready = 1'b0;
        send1(32'h0010_0113, 64'h400);
        send1(32'h0020_0193, 64'h404);
        flush = 1'b1;
        send1(32'h0030_0213, 64'h408);
        flush = 1'b0;
        check("flush.out_valid", 64'(obs_valid[0]), 64'd0);
        check("flush.in_ready", 64'(obs_ready[0]), 64'd1);
        out_ready = 1'b1;
        tick();
        tick();
        check("flush.nothing_emitted", 64'(obs_valid[0]), 64'd0);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom} & ~64'h3;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
